// File: rtl/r5p_mouse_mem.sv
// r5p_mouse_mem: word-organised TCL bus slave memory for the R5P Mouse core.
// Byte-enabled writes, registered reads, wait states, range errors, x0 guard.
module r5p_mouse_mem #(
    parameter logic [31:0] MEM_ADR = 32'h0000_0000,
    parameter int unsigned MEM_SIZ = 4096,
    parameter logic [31:0] GPR_ADR = 32'h0000_0F80,
    parameter int unsigned WAIT    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_vld,
    input  logic        bus_wen,
    input  logic [31:0] bus_adr,
    input  logic [3:0]  bus_ben,
    input  logic [31:0] bus_wdt,
    output logic [31:0] bus_rdt,
    output logic        bus_err,
    output logic        bus_rdy
);

    localparam int unsigned AW  = $clog2(MEM_SIZ);
    localparam int unsigned DEP = MEM_SIZ / 4;
    localparam logic [3:0]  WTS = WAIT[3:0];

    logic [31:0]   mem [DEP];
    logic [3:0]    cnt;
    logic          trn;
    logic          in_rng;
    logic          is_x0;
    logic [AW-3:0] idx;
    logic          unused;

    assign unused = ^bus_adr[1:0];

    assign idx     = bus_adr[AW-1:2];
    assign in_rng  = (bus_adr[31:AW] == MEM_ADR[31:AW]);
    assign is_x0   = (bus_adr[AW-1:2] == GPR_ADR[AW-1:2]);
    assign bus_rdy = (cnt == WTS);
    assign trn     = bus_vld & bus_rdy;

    // wait-state counter: counts while requested, clears on transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (trn) begin
            cnt <= 4'd0;
        end else if (bus_vld && (cnt != WTS)) begin
            cnt <= cnt + 4'd1;
        end
    end

    // byte-lane write into the array; x0 word and out-of-range writes dropped
    always_ff @(posedge clk) begin
        if (trn && bus_wen && in_rng && !is_x0) begin
            for (int i = 0; i < 4; i++) begin
                if (bus_ben[i]) begin
                    mem[idx][8*i +: 8] <= bus_wdt[8*i +: 8];
                end
            end
        end
    end

    // registered read data and error flag, held between transfers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_rdt <= 32'h0;
            bus_err <= 1'b0;
        end else if (trn) begin
            bus_err <= ~in_rng;
            if (!bus_wen) begin
                bus_rdt <= (in_rng && !is_x0) ? mem[idx] : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_r5p_mouse_mem.sv
// tb_r5p_mouse_mem: directed scoreboard bench for r5p_mouse_mem.
// Two instances: zero wait states and three wait states.
module tb_r5p_mouse_mem;

    typedef struct {
        logic [31:0] rdt;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;

    logic        v0, w0, err0, rdy0;
    logic [31:0] a0, d0, rdt0;
    logic [3:0]  b0;

    logic        v3, w3, err3, rdy3;
    logic [31:0] a3, d3, rdt3;
    logic [3:0]  b3;

    exp_t q0[$];
    exp_t q3[$];
    exp_t e;

    int checks = 0;
    int errors = 0;

    logic [31:0] model;
    logic [31:0] pat;

    r5p_mouse_mem #(.WAIT(0)) dut0 (
        .clk(clk), .rst(rst),
        .bus_vld(v0), .bus_wen(w0), .bus_adr(a0),
        .bus_ben(b0), .bus_wdt(d0),
        .bus_rdt(rdt0), .bus_err(err0), .bus_rdy(rdy0)
    );

    r5p_mouse_mem #(.WAIT(3)) dut3 (
        .clk(clk), .rst(rst),
        .bus_vld(v3), .bus_wen(w3), .bus_adr(a3),
        .bus_ben(b3), .bus_wdt(d3),
        .bus_rdt(rdt3), .bus_err(err3), .bus_rdy(rdy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic x0(input logic wen, input logic [31:0] adr,
                      input logic [3:0] ben, input logic [31:0] wdt,
                      input logic [31:0] erdt, input logic eerr,
                      input string tag);
        exp_t ex;
        @(negedge clk);
        v0 = 1'b1; w0 = wen; a0 = adr; b0 = ben; d0 = wdt;
        ex.rdt = erdt; ex.err = eerr;
        q0.push_back(ex);
        chk({tag, "_rdy"}, {31'h0, rdy0}, 32'h1);
        @(posedge clk);
        #1;
        v0 = 1'b0;
        ex = q0.pop_front();
        chk({tag, "_rdt"}, rdt0, ex.rdt);
        chk({tag, "_err"}, {31'h0, err0}, {31'h0, ex.err});
    endtask

    task automatic x3(input logic wen, input logic [31:0] adr,
                      input logic [3:0] ben, input logic [31:0] wdt,
                      input logic [31:0] erdt, input logic eerr,
                      input string tag);
        exp_t ex;
        int n;
        @(negedge clk);
        v3 = 1'b1; w3 = wen; a3 = adr; b3 = ben; d3 = wdt;
        ex.rdt = erdt; ex.err = eerr;
        q3.push_back(ex);
        n = 0;
        while (!rdy3 && n < 32) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_wait"}, {31'h0, rdy3}, 32'h1);
        chk({tag, "_nwait"}, n, 32'd3);
        @(posedge clk);
        #1;
        v3 = 1'b0;
        ex = q3.pop_front();
        chk({tag, "_rdt"}, rdt3, ex.rdt);
        chk({tag, "_err"}, {31'h0, err3}, {31'h0, ex.err});
    endtask

    initial begin
        rst = 1'b1;
        v0 = 0; w0 = 0; a0 = 0; b0 = 0; d0 = 0;
        v3 = 0; w3 = 0; a3 = 0; b3 = 0; d3 = 0;
        #12;
        chk("rst_rdt0", rdt0, 32'h0);
        chk("rst_err0", {31'h0, err0}, 32'h0);
        chk("rst_rdy0", {31'h0, rdy0}, 32'h1);
        chk("rst_rdy3", {31'h0, rdy3}, 32'h0);
        chk("rst_err3", {31'h0, err3}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        x0(1, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 0, "wr_full");
        x0(0, 32'h100, 4'h0, 0, 32'hDEADBEEF, 0, "rd_full");
        x0(1, 32'h100, 4'b0101, 32'h11223344, 32'hDEADBEEF, 0, "wr_ben");
        x0(0, 32'h100, 4'hF, 0, 32'hDE22BE44, 0, "rd_ben");
        x0(1, 32'hF80, 4'hF, 32'h5, 32'hDE22BE44, 0, "wr_x0");
        x0(1, 32'hF84, 4'hF, 32'h7, 32'hDE22BE44, 0, "wr_x1");
        x0(0, 32'hF80, 4'hF, 0, 32'h0, 0, "rd_x0");
        x0(0, 32'hF84, 4'hF, 0, 32'h7, 0, "rd_x1");
        x0(0, 32'h2000, 4'hF, 0, 32'h0, 1, "rd_oor");
        x0(0, 32'h103, 4'hF, 0, 32'hDE22BE44, 0, "rd_unal");
        x0(1, 32'h1100, 4'hF, 32'hFFFFFFFF, 32'hDE22BE44, 1, "wr_oor");
        x0(0, 32'h100, 4'hF, 0, 32'hDE22BE44, 0, "rd_after_oor");

        model = 32'h0F1E2D3C;
        x0(1, 32'h200, 4'hF, model, 32'hDE22BE44, 0, "ben_init");
        for (int i = 0; i < 16; i++) begin
            pat = {4{i[3:0], 4'hA}} ^ 32'h5A00_00A5;
            for (int k = 0; k < 4; k++) begin
                if (i[k]) model[8*k +: 8] = pat[8*k +: 8];
            end
            x0(1, 32'h200, i[3:0], pat, rdt0, 0, "ben_wr");
            x0(0, 32'h200, 4'h0, 0, model, 0, "ben_rd");
        end

        x3(1, 32'h40, 4'hF, 32'hA5A50F0F, 32'h0, 0, "w3_wr");
        x3(0, 32'h40, 4'hF, 0, 32'hA5A50F0F, 0, "w3_rd");

        @(negedge clk);
        v3 = 1'b1; w3 = 1'b0; a3 = 32'h2000;
        for (int i = 0; i < 12; i++) begin
            if (q3.size() > 0) begin
                e = q3.pop_front();
                chk("seq_rdt", rdt3, e.rdt);
                chk("seq_err", {31'h0, err3}, {31'h0, e.err});
            end
            chk("seq_rdy", {31'h0, rdy3}, {31'h0, (i % 4) == 3});
            if (rdy3) begin
                e.rdt = 32'h0; e.err = 1'b1;
                q3.push_back(e);
            end
            @(negedge clk);
        end
        e = q3.pop_front();
        chk("seq_last_err", {31'h0, err3}, {31'h0, e.err});
        chk("seq_last_rdy", {31'h0, rdy3}, 32'h0);

        @(negedge clk);
        @(negedge clk);
        chk("pre_drop_rdy", {31'h0, rdy3}, 32'h0);
        v3 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("drop_hold_rdy", {31'h0, rdy3}, 32'h0);
        v3 = 1'b1; a3 = 32'h40;
        @(negedge clk);
        chk("resume_rdy", {31'h0, rdy3}, 32'h1);
        e.rdt = 32'hA5A50F0F; e.err = 1'b0;
        q3.push_back(e);
        @(negedge clk);
        e = q3.pop_front();
        chk("resume_rdt", rdt3, e.rdt);
        chk("resume_err", {31'h0, err3}, {31'h0, e.err});

        a3 = 32'h2000;
        repeat (3) @(negedge clk);
        chk("oor3_rdy", {31'h0, rdy3}, 32'h1);
        @(negedge clk);
        chk("oor3_err", {31'h0, err3}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_rdy", {31'h0, rdy3}, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rdy3", {31'h0, rdy3}, 32'h0);
        chk("arst_rdt3", rdt3, 32'h0);
        chk("arst_err3", {31'h0, err3}, 32'h0);
        chk("arst_rdt0", rdt0, 32'h0);
        chk("arst_rdy0", {31'h0, rdy0}, 32'h1);
        v3 = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        x3(0, 32'h40, 4'hF, 0, 32'hA5A50F0F, 0, "post_rst3");
        x0(0, 32'h100, 4'hF, 0, 32'hDE22BE44, 0, "post_rst0");
        x0(0, 32'h200, 4'hF, 0, model, 0, "post_rst0b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
